// File: rtl/chan_pkg.sv
// Shared constants, FSM state type and round-robin helper for the channel link.
package chan_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Next round-robin start point; N_CH is a power of two so the add wraps.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
        return ptr + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_pick
    import chan_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_tx_arbiter.sv
// Four one-entry channel buffers arbitrated round-robin onto a tagged
// sel/data output with a valid/ready handshake and a transfer counter.
module chan_tx_arbiter
    import chan_pkg::*;
#(
    parameter int DW    = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      in_valid,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic [N_CH-1:0]      in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     sel,
    output logic [DW-1:0]        data,
    output logic [CNT_W-1:0]     sent_cnt
);

    state_e                   state_q, state_d;
    logic [N_CH-1:0]          pend_q, pend_d;
    logic [N_CH-1:0][DW-1:0]  buf_q, buf_d;
    logic [SEL_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [DW-1:0]            data_q, data_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [N_CH-1:0]          cap;
    logic [SEL_W-1:0]         gnt;
    logic                     any;
    logic                     load;

    // Buffer is free when empty; nothing is accepted while reset is held.
    assign in_ready  = ~pend_q & {N_CH{~rst}};
    assign cap       = in_valid & in_ready;

    assign out_valid = (state_q == SEND);
    assign sel       = sel_q;
    assign data      = data_q;
    assign sent_cnt  = cnt_q;

    // Picker sees registered pend only: same-cycle captures wait a cycle.
    rr_pick u_pick (
        .req     (pend_q),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt),
        .any     (any)
    );

    // Next-state: handshake completion, grant loading and buffer captures.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        buf_d    = buf_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        load     = 1'b0;

        case (state_q)
            IDLE: load = any;
            SEND: begin
                if (out_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    load  = any;
                    if (!any) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant needs pend set, which blocks a capture on the same channel.
        if (load) begin
            sel_d        = gnt;
            data_d       = buf_q[gnt];
            pend_d[gnt]  = 1'b0;
            rr_ptr_d     = rr_next(gnt);
            state_d      = SEND;
        end

        for (int i = 0; i < N_CH; i++) begin
            if (cap[i]) begin
                pend_d[i] = 1'b1;
                buf_d[i]  = in_data[i*DW +: DW];
            end
        end
    end

    // State registers with synchronous reset discarding all held words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            buf_q    <= '0;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            buf_q    <= buf_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_chan_tx_arbiter.sv
// Self-checking bench for chan_tx_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_chan_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  sel;
    logic [3:0]  data;
    logic [7:0]  sent_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel word queues, a rotating start point,
    // and the word currently offered downstream.
    logic [3:0] mq [4][$];
    int         mptr;
    bit         mvalid;
    logic [1:0] msel;
    logic [3:0] mdata;
    logic [7:0] mcnt;
    int         mtotal;

    chan_tx_arbiter #(.DW(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .data      (data),
        .sent_cnt  (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = !rst && (mq[i].size() == 0);
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        bit rdy [4];
        bit found;
        int c;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            mptr = 0; mvalid = 0; msel = 0; mdata = 0; mcnt = 0; mtotal = 0;
        end else begin
            for (int i = 0; i < 4; i++) rdy[i] = (mq[i].size() == 0);
            if (mvalid && out_ready) begin
                mcnt = mcnt + 8'd1;
                mtotal++;
                mvalid = 0;
            end
            if (!mvalid) begin
                found = 0;
                for (int o = 0; o < 4; o++) begin
                    c = (mptr + o) % 4;
                    if (!found && mq[c].size() > 0) begin
                        found  = 1;
                        msel   = 2'(c);
                        mdata  = mq[c].pop_front();
                        mptr   = (c + 1) % 4;
                        mvalid = 1;
                    end
                end
            end
            for (int i = 0; i < 4; i++)
                if (in_valid[i] && rdy[i]) mq[i].push_back(in_data[i*4 +: 4]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; in_data = 16'hFFFF; out_ready = 1'b0;
        step(); step();
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++; if (data !== 4'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data); end
        checks++; if (sent_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", sent_cnt); end
        rst = 1'b0; in_valid = 4'b0000;
        #1;
        checks++; if (in_ready !== 4'b1111) begin errors++; $display("FAIL release_in_ready got %b exp 1111", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 4'b0100; in_data = 16'h0A00;
        step();
        in_valid = 4'b0000;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || sel !== 2'd2 || data !== 4'hA) begin
            errors++; $display("FAIL single_word got v%b s%0d d%h exp v1 s2 dA", out_valid, sel, data); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", out_valid); end
        checks++; if (sent_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", sent_cnt); end
    endtask

    task automatic test_round_robin();
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b1111; in_data = 16'h4321;
        step();
        in_valid = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            step();
            checks++; if (out_valid !== 1'b1 || sel !== 2'(j) || data !== 4'(j + 1)) begin
                errors++; $display("FAIL rr_order%0d got v%b s%0d d%h exp v1 s%0d d%0h", j, out_valid, sel, data, j, j + 1); end
            if (j == 0) begin
                checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL rr_refill_ready got %b exp 1", in_ready[0]); end
                in_valid = 4'b0001; in_data = 16'h0005;
            end
            if (j == 1) in_valid = 4'b0000;
        end
        step();
        checks++; if (out_valid !== 1'b1 || sel !== 2'd0 || data !== 4'h5) begin
            errors++; $display("FAIL rr_refill got v%b s%0d d%h exp v1 s0 d5", out_valid, sel, data); end
        step();
        checks++; if (out_valid !== 1'b0 || sent_cnt !== 8'd5) begin
            errors++; $display("FAIL rr_end got v%b c%0d exp v0 c5", out_valid, sent_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] c0;
        out_ready = 1'b0;
        in_valid = 4'b0010; in_data = 16'h0070;
        step();
        in_data = 16'h0090;
        step();
        checks++; if (out_valid !== 1'b1 || sel !== 2'd1 || data !== 4'h7 || in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL bp_grant got v%b s%0d d%h r%b exp v1 s1 d7 r1", out_valid, sel, data, in_ready[1]); end
        step();
        in_valid = 4'b0000;
        c0 = mcnt;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++; if (out_valid !== 1'b1 || sel !== 2'd1 || data !== 4'h7 || in_ready[1] !== 1'b0 || sent_cnt !== c0) begin
                errors++; $display("FAIL bp_hold%0d got v%b s%0d d%h r%b c%0d exp v1 s1 d7 r0 c%0d", n, out_valid, sel, data, in_ready[1], sent_cnt, c0); end
        end
        out_ready = 1'b1;
        step();
        checks++; if (sent_cnt !== c0 + 8'd1 || sel !== 2'd1 || data !== 4'h9 || in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL bp_release got c%0d s%0d d%h r%b exp c%0d s1 d9 r1", sent_cnt, sel, data, in_ready[1], c0 + 8'd1); end
        step();
        checks++; if (out_valid !== 1'b0 || sent_cnt !== c0 + 8'd2) begin
            errors++; $display("FAIL bp_end got v%b c%0d exp v0 c%0d", out_valid, sent_cnt, c0 + 8'd2); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            step();
            checks++; if (out_valid !== mvalid) begin errors++; $display("FAIL rand_valid@%0d got %b exp %b", n, out_valid, mvalid); end
            checks++; if (sel !== msel) begin errors++; $display("FAIL rand_sel@%0d got %0d exp %0d", n, sel, msel); end
            checks++; if (data !== mdata) begin errors++; $display("FAIL rand_data@%0d got %h exp %h", n, data, mdata); end
            checks++; if (sent_cnt !== mcnt) begin errors++; $display("FAIL rand_cnt@%0d got %0d exp %0d", n, sent_cnt, mcnt); end
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready@%0d got %b exp %b", n, in_ready, exp_ready()); end
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_wrap();
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        while (mtotal < 256 && n < 2000) begin
            in_data = 16'($urandom);
            step();
            n++;
        end
        in_valid = 4'b0000;
        checks++; if (mtotal != 256) begin errors++; $display("FAIL wrap_timeout got %0d transfers exp 256", mtotal); end
        checks++; if (sent_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got %0d exp 0", sent_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        in_valid = 4'b1111; in_data = 16'hBCDE;
        step();
        in_valid = 4'b0000;
        step();
        checks++; if (out_valid !== 1'b1 || in_ready !== 4'b0001) begin
            errors++; $display("FAIL mid_setup got v%b r%b exp v1 r0001", out_valid, in_ready); end
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || sent_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_reset got v%b c%0d exp v0 c0", out_valid, sent_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b1111) begin errors++; $display("FAIL mid_pend_clear got %b exp 1111", in_ready); end
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++; if (out_valid !== 1'b0 || sent_cnt !== 8'd0) begin
                errors++; $display("FAIL mid_stale%0d got v%b c%0d exp v0 c0", n, out_valid, sent_cnt); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b0000; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
